// File: rtl/kernel_acc_unit.sv
// Windowed L1-distance accumulator: per-lane |if - w| (exact or one's-complement
// approximation), lane adder tree, and a DEPTH-beat window sum with a stalling result handshake.
module kernel_acc_unit #(
    parameter  int NBIT  = 8,
    parameter  int LANES = 4,
    parameter  int DEPTH = 9,
    localparam int ACCW  = NBIT + $clog2(LANES) + $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [LANES*NBIT-1:0] i_if,
    input  logic [LANES*NBIT-1:0] i_w,
    input  logic                  i_exact,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ACCW-1:0]       o_sum
);

    localparam int            CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

    // Approximate mode drops the +1 of the two's-complement negate.
    function automatic logic [NBIT-1:0] lane_mag(input logic [NBIT-1:0] a,
                                                 input logic [NBIT-1:0] b,
                                                 input logic            exact);
        logic [NBIT-1:0] d;
        logic [NBIT-1:0] x;
        d = a - b;
        x = d ^ {NBIT{d[NBIT-1]}};
        if (exact) begin
            lane_mag = x + NBIT'(d[NBIT-1]);
        end else begin
            lane_mag = x;
        end
    endfunction

    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_load;
    logic [NBIT-1:0]       w_lane [LANES];
    logic [ACCW-1:0]       w_tree;
    logic [ACCW-1:0]       w_total;

    logic [NBIT-1:0]       r_lane [LANES];
    logic                  r_s1_valid;
    logic                  r_s1_last;
    logic [CW-1:0]         r_cnt;
    logic [ACCW-1:0]       r_acc;
    logic [ACCW-1:0]       r_sum;
    logic                  r_valid;

    // A pending, unaccepted result freezes the whole pipeline.
    assign o_ready     = i_rst | ~(r_valid & ~i_ready);
    assign w_accept    = i_valid & o_ready;
    assign w_last_beat = (r_cnt == LAST_CNT);
    assign w_load      = r_s1_valid & r_s1_last;
    assign o_valid     = r_valid;
    assign o_sum       = r_sum;

    // Per-lane magnitude of the incoming beat.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_lane[k] = lane_mag(i_if[k*NBIT +: NBIT], i_w[k*NBIT +: NBIT], i_exact);
        end
    end

    // Full-width lane sum plus running window total.
    always_comb begin
        w_tree = {ACCW{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            w_tree = w_tree + ACCW'(r_lane[k]);
        end
        w_total = r_acc + w_tree;
    end

    // Stage-1 lane capture, beat counter, stage-2 accumulate and result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_acc      <= {ACCW{1'b0}};
            r_sum      <= {ACCW{1'b0}};
            r_valid    <= 1'b0;
        end else if (o_ready) begin
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept & w_last_beat;
            if (w_accept) begin
                for (int k = 0; k < LANES; k++) begin
                    r_lane[k] <= w_lane[k];
                end
                r_cnt <= w_last_beat ? {CW{1'b0}} : r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_sum <= w_total;
                    r_acc <= {ACCW{1'b0}};
                end else begin
                    r_acc <= w_total;
                end
            end
            // Advancing implies any presented result is being taken this edge.
            r_valid <= w_load;
        end
    end

endmodule

// File: tb/tb_kernel_acc_unit.sv
// Scoreboard bench for kernel_acc_unit: a stimulus process feeds beats into an arithmetic
// reference model that queues window sums; a monitor pops and compares each presented result.
module tb_kernel_acc_unit;

    localparam int NBIT  = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 3;
    localparam int ACCW  = NBIT + $clog2(LANES) + $clog2(DEPTH) + 1;

    typedef struct {
        int sum;
        int acc_edge;
        bit chk_lat;
        int known;
    } exp_t;

    logic                  clk      = 1'b0;
    logic                  rst      = 1'b1;
    logic                  in_valid = 1'b0;
    logic [LANES*NBIT-1:0] in_if    = '0;
    logic [LANES*NBIT-1:0] in_w     = '0;
    logic                  in_exact = 1'b0;
    logic                  ds_ready = 1'b1;
    logic                  out_ready;
    logic                  out_valid;
    logic [ACCW-1:0]       out_sum;

    exp_t sb[$];
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   results_seen = 0;
    int   m_acc        = 0;
    int   m_cnt        = 0;
    int   next_known   = -1;
    bit   lat_ok       = 1'b1;
    bit   rnd_rdy      = 1'b0;
    bit   rdy_fixed    = 1'b1;
    bit   mon_en       = 1'b0;

    kernel_acc_unit #(.NBIT(NBIT), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_if    (in_if),
        .i_w     (in_w),
        .i_exact (in_exact),
        .o_valid (out_valid),
        .i_ready (ds_ready),
        .o_sum   (out_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) ds_ready = rnd_rdy ? ($urandom_range(3) != 0) : rdy_fixed;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // |a-b| taken as signed NBIT difference; approximation is one less for negative d.
    function automatic int lane_ref(input int a, input int b, input bit ex);
        int sd;
        sd = (a - b) & ((1 << NBIT) - 1);
        if (sd >= (1 << (NBIT - 1))) sd = sd - (1 << NBIT);
        if (sd < 0) return ex ? -sd : -sd - 1;
        return sd;
    endfunction

    function automatic logic [LANES*NBIT-1:0] all_l(input logic [NBIT-1:0] v);
        logic [LANES*NBIT-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*NBIT +: NBIT] = v;
        return r;
    endfunction

    task automatic send_beat(input logic [LANES*NBIT-1:0] a, input logic [LANES*NBIT-1:0] b,
                             input bit ex);
        int waits = 0;
        int edge_no;
        @(negedge clk);
        in_valid = 1'b1;
        in_if    = a;
        in_w     = b;
        in_exact = ex;
        #1;
        while (!out_ready) begin
            waits = waits + 1;
            if (waits > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: o_ready stayed 0 for %0d cycles, expected 1", waits);
                return;
            end
            @(negedge clk);
            #1;
        end
        edge_no = cyc + 1;
        for (int k = 0; k < LANES; k++)
            m_acc += lane_ref(int'(a[k*NBIT +: NBIT]), int'(b[k*NBIT +: NBIT]), ex);
        m_cnt++;
        if (m_cnt == DEPTH) begin
            sb.push_back('{sum: m_acc, acc_edge: edge_no, chk_lat: lat_ok, known: next_known});
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_window(input logic [LANES*NBIT-1:0] a, input logic [LANES*NBIT-1:0] b,
                               input bit ex, input int known);
        next_known = known;
        repeat (DEPTH) send_beat(a, b, ex);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        m_acc    = 0;
        m_cnt    = 0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_o_ready", out_ready, 1);
        rst = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still expected, expected 0", sb.size());
        end
        idle(2);
    endtask

    // Monitor: compares every newly presented result against the scoreboard head.
    initial begin
        bit   held = 1'b0;
        int   held_sum = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("o_ready_rule", out_ready, rst || !(out_valid && !ds_ready));
                if (out_valid) begin
                    if (!held) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_result: o_sum=%0d with no result expected", out_sum);
                        end else begin
                            e = sb.pop_front();
                            chk("o_sum", out_sum, e.sum);
                            if (e.known >= 0) chk("o_sum_known", out_sum, e.known);
                            if (e.chk_lat) chk("latency_edge", cyc + 1, e.acc_edge + 2);
                            results_seen++;
                        end
                        held_sum = int'(out_sum);
                    end else begin
                        chk("o_sum_stable", out_sum, held_sum);
                    end
                    held = !ds_ready;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        int base;
        logic [NBIT-1:0] v;
        logic [LANES*NBIT-1:0] a;
        logic [LANES*NBIT-1:0] b;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_o_valid", out_valid, 0);
        chk("reset_o_sum", out_sum, 0);
        chk("reset_o_ready", out_ready, 1);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Positive differences: both modes give the exact magnitude.
        send_window(all_l(8'd9), all_l(8'd5), 1'b0, 48);
        send_window(all_l(8'd9), all_l(8'd5), 1'b1, 48);
        idle(2);
        drain();

        // Negative differences: approximation loses one per lane.
        send_window(all_l(8'd5), all_l(8'd9), 1'b0, 36);
        send_window(all_l(8'd5), all_l(8'd9), 1'b1, 48);
        idle(2);
        drain();

        // Wraparound lane: 0x7F - 0x80 = -1.
        v = NBIT'($urandom);
        a = all_l(v);
        b = all_l(v);
        a[NBIT-1:0] = 8'h7F;
        b[NBIT-1:0] = 8'h80;
        send_window(a, b, 1'b0, 0);
        send_window(a, b, 1'b1, 3);
        idle(2);
        drain();

        // Back-to-back windows, continuous valid.
        base = results_seen;
        for (int i = 0; i < 4; i++) send_window(LANES*NBIT'($urandom), LANES*NBIT'($urandom), 1'($urandom), -1);
        idle(2);
        drain();
        chk("b2b_results", results_seen - base, 4);

        // Downstream stall with a pending result and another window offered.
        lat_ok    = 1'b0;
        rdy_fixed = 1'b0;
        idle(2);
        send_window(all_l(8'd9), all_l(8'd5), 1'b0, 48);
        fork
            send_window(all_l(8'd9), all_l(8'd5), 1'b1, 48);
            begin
                repeat (8) @(negedge clk);
                #1;
                chk("stall_o_ready", out_ready, 0);
                chk("stall_o_valid", out_valid, 1);
                chk("stall_o_sum", out_sum, 48);
                rdy_fixed = 1'b1;
            end
        join
        idle(2);
        drain();
        lat_ok = 1'b1;

        // Reset mid-window discards the partial sum.
        base       = results_seen;
        next_known = -1;
        send_beat(all_l(8'd9), all_l(8'd5), 1'b0);
        send_beat(all_l(8'd9), all_l(8'd5), 1'b0);
        do_reset(1);
        send_window(all_l(8'd9), all_l(8'd5), 1'b0, 48);
        idle(2);
        drain();
        chk("reset_window_count", results_seen - base, 1);

        // Random data, modes, bubbles and downstream back-pressure.
        lat_ok     = 1'b0;
        rnd_rdy    = 1'b1;
        next_known = -1;
        base       = results_seen;
        for (int i = 0; i < 30; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                send_beat(LANES*NBIT'($urandom), LANES*NBIT'($urandom), 1'($urandom));
                if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
            end
        end
        idle(2);
        rnd_rdy = 1'b0;
        drain();
        chk("random_results", results_seen - base, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_acc_unit.md
KERNEL_ACC_UNIT -- requirements
Module: kernel_acc_unit

Interface
REQ-001 SHALL have parameter NBIT, default 8, operand width per lane.
REQ-002 SHALL have parameter LANES, default 4, operand pairs per beat (>=1).
REQ-003 SHALL have parameter DEPTH, default 9, beats per accumulation window (>=1).
REQ-004 SHALL derive ACCW = NBIT + clog2(LANES) + clog2(DEPTH) + 1 as the accumulator and result width.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 i_clk  input  1  clock, all state on rising edge.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_valid  input  1  input beat valid.
REQ-009 o_ready  output  1  block accepts a beat this cycle.
REQ-010 i_if  input  LANES*NBIT  input-feature operands, lane k at bits [k*NBIT +: NBIT].
REQ-011 i_w  input  LANES*NBIT  weight operands, same packing.
REQ-012 i_exact  input  1  per-beat mode: 1 exact |d|, 0 one's-complement approximation.
REQ-013 o_valid  output  1  window result valid.
REQ-014 i_ready  input  1  downstream accepts result.
REQ-015 o_sum  output  ACCW  unsigned window L1 sum.

Function
REQ-016 Beat accepted when i_valid & o_ready at a rising edge; i_exact is sampled with the beat.
REQ-017 Per lane d = i_if - i_w, modulo 2^NBIT, two's complement; s = d[NBIT-1]; no overflow detection.
REQ-018 Approx mode: lane value = d XOR {NBIT{s}}; exact mode: lane value = (d XOR {NBIT{s}}) + s, zero-extended.
REQ-019 Stage 1 SHALL register all LANES lane values and a beat-valid/last flag one edge after acceptance.
REQ-020 Stage 2 SHALL sum all lanes (adder tree, full width, no truncation) and add it to the accumulator.
REQ-021 A beat counter SHALL count accepted beats 0..DEPTH-1 and wrap to 0 after the DEPTH-th beat.
REQ-022 On the DEPTH-th beat the stage-2 sum (accumulator + tree) SHALL load o_sum, set o_valid, and clear the accumulator in the same edge.
REQ-023 Latency: last beat accepted at edge t -> o_valid high from edge t+2.
REQ-024 Next window's first beat SHALL start from accumulator 0, with no merging of windows.
REQ-025 o_valid SHALL stay high and o_sum stable until o_valid & i_ready at an edge, then o_valid clears unless a new result loads that same edge.
REQ-026 o_ready = ~(o_valid & ~i_ready); when low, stages 1 and 2 and the counter SHALL hold (global stall), and no beat is lost or duplicated.
REQ-027 Simultaneous result handoff and new result load in the same edge SHALL present the new result, with no bubble.
REQ-028 Pipeline bubbles (i_valid low) SHALL not advance the counter or alter the accumulator.
REQ-029 DEPTH=1: every beat produces a result; LANES=1: tree is a pass-through.

Reset
REQ-030 i_rst high at an edge SHALL clear o_valid, o_sum, accumulator, beat counter and stage-1 valid to 0, overriding any handshake that edge.
REQ-031 Reset mid-window SHALL discard partial accumulation; the first beat after reset starts a new window.
REQ-032 During reset o_ready SHALL be 1 (o_valid is 0).

Verification (NBIT=8, LANES=4, DEPTH=3)
REQ-033 All lanes if=9,w=5, 3 beats, i_ready=1, either mode -> one o_valid pulse, o_sum=48, 2 cycles after last beat.
REQ-034 All lanes if=5,w=9, 3 beats: i_exact=0 -> o_sum=36 (lane 3); i_exact=1 -> o_sum=48.
REQ-035 Lane0 if=0x7F,w=0x80, others equal, 1 window: approx -> o_sum=0; exact -> o_sum=3.
REQ-036 i_ready=0 with result pending and 3 more beats offered -> o_ready=0, o_sum held at 48; release i_ready -> both windows delivered (48, then next) in order, no loss.
REQ-037 2 beats of if=9,w=5, then i_rst for 1 cycle, then 3 beats of if=9,w=5 -> only one result, o_sum=48.
REQ-038 Back-to-back windows with i_ready=1 and continuous i_valid -> o_valid every 3rd cycle, o_ready never drops.
